// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like req/addr_ok/data_ok bus. An in-order pending queue holds each
// request for a fixed latency, then completes it against a word-addressed memory model.
module sram_like_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned     PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);
  localparam logic [3:0]      DepthCnt = 4'(DEPTH);
  localparam logic [3:0]      AgeMax   = 4'(LATENCY);
  localparam logic [3:0]      AgeReady = 4'(LATENCY - 1);
  localparam bit              LatOne   = (LATENCY == 1);

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [DEPTH-1:0]                 valid_q, valid_d;
  logic [DEPTH-1:0]                 wr_q, wr_d;
  logic [DEPTH-1:0][1:0]            size_q, size_d;
  logic [DEPTH-1:0][3:0]            wstrb_q, wstrb_d;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DEPTH-1:0][31:0]           wdata_q, wdata_d;
  logic [DEPTH-1:0][3:0]            age_q, age_d;
  logic [PtrW-1:0]                  head_q, head_d;
  logic [PtrW-1:0]                  tail_q, tail_d;
  logic [3:0]                       count_q, count_d;
  logic                             data_ok_q, data_ok_d;
  logic [31:0]                      rdata_q, rdata_d;

  logic                  accept, bypass, head_ready, complete, push, pop, mem_we;
  logic                  c_wr;
  logic [3:0]            c_wstrb;
  logic [ADDR_WIDTH-1:0] c_idx, in_idx;
  logic [31:0]           c_wdata;
  logic                  unused_ok;

  assign in_idx    = addr[ADDR_WIDTH+1:2];
  // size rides along with each entry but never affects the access
  assign unused_ok = ^{size_q, addr};

  always_comb begin
    addr_ok    = req & ~stall & (count_q < DepthCnt);
    accept     = addr_ok;
    head_ready = valid_q[head_q] & (age_q[head_q] >= AgeReady);
    // With a one-cycle latency a request arriving at an empty queue completes in its accept cycle
    bypass     = LatOne & accept & (count_q == 4'd0);
    complete   = ~stall & (head_ready | bypass);
    push       = accept & ~bypass;
    pop        = head_ready & ~stall;

    if (bypass) begin
      c_wr    = wr;
      c_wstrb = wstrb;
      c_idx   = in_idx;
      c_wdata = wdata;
    end else begin
      c_wr    = wr_q[head_q];
      c_wstrb = wstrb_q[head_q];
      c_idx   = idx_q[head_q];
      c_wdata = wdata_q[head_q];
    end

    valid_d = valid_q;
    wr_d    = wr_q;
    size_d  = size_q;
    wstrb_d = wstrb_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    age_d   = age_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (age_q[i] != AgeMax)) age_d[i] = age_q[i] + 4'd1;
    end
    if (pop) valid_d[head_q] = 1'b0;
    // Age is cycles since acceptance, so the entry has already aged once when it lands
    if (push) begin
      valid_d[tail_q] = 1'b1;
      wr_d[tail_q]    = wr;
      size_d[tail_q]  = size;
      wstrb_d[tail_q] = wstrb;
      idx_d[tail_q]   = in_idx;
      wdata_d[tail_q] = wdata;
      age_d[tail_q]   = 4'd1;
    end

    head_d = head_q;
    tail_d = tail_q;
    if (pop)  head_d = (head_q == LastPtr) ? '0 : head_q + PtrW'(1);
    if (push) tail_d = (tail_q == LastPtr) ? '0 : tail_q + PtrW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase

    data_ok_d = complete;
    rdata_d   = (complete && !c_wr) ? mem[c_idx] : 32'd0;
    mem_we    = complete & c_wr & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      age_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      age_q     <= age_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    size_q  <= size_d;
    wstrb_q <= wstrb_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (c_wstrb[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;

endmodule
